// File: rtl/risc_v_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode constants,
// FSM state encoding and an opcode legality helper.
package risc_v_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // IDLE: result register empty, HOLD: result register full
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Returns 1 when the opcode belongs to the supported set
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/risc_v_alu.sv
// Purely combinational ALU. Unknown opcodes produce a zero result and
// raise the illegal flag.
module risc_v_alu
  import risc_v_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_illegal
);

  logic [DATA_W-1:0] result_s;

  // Opcode decode; arithmetic wraps modulo 2^DATA_W, SLT compares unsigned
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (alu_ctl)
      ALU_AND: result_s = alu_a & alu_b;
      ALU_OR:  result_s = alu_a | alu_b;
      ALU_ADD: result_s = alu_a + alu_b;
      ALU_SUB: result_s = alu_a - alu_b;
      ALU_SLT: result_s = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      ALU_NOR: result_s = ~(alu_a | alu_b);
      default: result_s = {DATA_W{1'b0}};
    endcase
  end

  assign alu_result  = result_s;
  assign alu_zero    = (result_s == {DATA_W{1'b0}});
  assign alu_illegal = ~is_legal_op(alu_ctl);

endmodule

// File: rtl/risc_v_alu_arb.sv
// Two-requester round-robin arbiter in front of a shared ALU with a
// single-entry result register and per-port saturating grant counters.
module risc_v_alu_arb
  import risc_v_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_port,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_illegal,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t        state_q, state_d;
  logic              rr_q, rr_d;
  logic              resp_port_q, resp_port_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic [CNT_W-1:0]  grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0]  grant_cnt1_q, grant_cnt1_d;

  logic              accept_s;
  logic              sel_port_s;
  logic              grant_s;
  logic [3:0]        op_ctl_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_zero_s;
  logic              alu_illegal_s;

  // Grant selection: decided only from valids, rr, state and resp_ready,
  // never from the operation payload. Reset forces both readies low.
  always_comb begin
    accept_s = (state_q == ST_IDLE) || resp_ready;
    if (req0_valid && req1_valid) begin
      sel_port_s = rr_q;
    end else if (req1_valid) begin
      sel_port_s = 1'b1;
    end else begin
      sel_port_s = 1'b0;
    end
    grant_s = accept_s && (req0_valid || req1_valid) && !sys_rst;
  end

  assign req0_ready = grant_s && !sel_port_s;
  assign req1_ready = grant_s && sel_port_s;

  // Operand mux feeding the shared ALU
  always_comb begin
    if (sel_port_s) begin
      op_ctl_s = req1_ctl;
      op_a_s   = req1_a;
      op_b_s   = req1_b;
    end else begin
      op_ctl_s = req0_ctl;
      op_a_s   = req0_a;
      op_b_s   = req0_b;
    end
  end

  risc_v_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_ctl     (op_ctl_s),
    .alu_a       (op_a_s),
    .alu_b       (op_b_s),
    .alu_result  (alu_result_s),
    .alu_zero    (alu_zero_s),
    .alu_illegal (alu_illegal_s)
  );

  // Next-state logic for the result FSM, round-robin pointer and counters
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    resp_port_d    = resp_port_q;
    resp_data_d    = resp_data_q;
    resp_zero_d    = resp_zero_q;
    resp_illegal_d = resp_illegal_q;
    grant_cnt0_d   = grant_cnt0_q;
    grant_cnt1_d   = grant_cnt1_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (resp_ready && !grant_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_s) begin
      rr_d           = ~sel_port_s;
      resp_port_d    = sel_port_s;
      resp_data_d    = alu_result_s;
      resp_zero_d    = alu_zero_s;
      resp_illegal_d = alu_illegal_s;
      if (!sel_port_s && (grant_cnt0_q != CNT_MAX)) begin
        grant_cnt0_d = grant_cnt0_q + CNT_ONE;
      end else begin
        grant_cnt0_d = grant_cnt0_q;
      end
      if (sel_port_s && (grant_cnt1_q != CNT_MAX)) begin
        grant_cnt1_d = grant_cnt1_q + CNT_ONE;
      end else begin
        grant_cnt1_d = grant_cnt1_q;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // FSM and result register; asynchronous reset discards any pending result
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      rr_q           <= 1'b0;
      resp_port_q    <= 1'b0;
      resp_data_q    <= {DATA_W{1'b0}};
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
      grant_cnt0_q   <= {CNT_W{1'b0}};
      grant_cnt1_q   <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      resp_port_q    <= resp_port_d;
      resp_data_q    <= resp_data_d;
      resp_zero_q    <= resp_zero_d;
      resp_illegal_q <= resp_illegal_d;
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
    end
  end

  assign resp_valid   = (state_q == ST_HOLD);
  assign resp_port    = resp_port_q;
  assign resp_data    = resp_data_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;
  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;

endmodule

// File: tb/tb_risc_v_alu_arb.sv
// Scoreboard bench for risc_v_alu_arb: directed vectors push expected
// results into a queue, a monitor pops and compares on each delivery.
module tb_risc_v_alu_arb;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam logic [63:0] ONES = {64{1'b1}};

  logic              sys_clk;
  logic              sys_rst;
  logic              req0_valid, req0_ready;
  logic [3:0]        req0_ctl;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [3:0]        req1_ctl;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              resp_valid, resp_ready, resp_port;
  logic [DATA_W-1:0] resp_data;
  logic              resp_zero, resp_illegal;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  typedef struct {
    logic        port;
    logic [63:0] data;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  risc_v_alu_arb #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_ctl     (req0_ctl),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_ctl     (req1_ctl),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_port    (resp_port),
    .resp_data    (resp_data),
    .resp_zero    (resp_zero),
    .resp_illegal (resp_illegal),
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered result must match the oldest expectation
  always @(negedge sys_clk) begin
    if (!sys_rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got port %0d data 0x%0h with empty scoreboard",
                 resp_port, resp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_port",    64'(resp_port),    64'(e.port));
        chk("resp_data",    resp_data,         e.data);
        chk("resp_zero",    64'(resp_zero),    64'(e.zero));
        chk("resp_illegal", 64'(resp_illegal), 64'(e.ill));
      end
    end
  end

  task automatic drive0(input logic v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
  endtask

  // One cycle: exp_g = 0/1 expected granted port, 2 = no grant
  task automatic step(input logic rdy, input int exp_g, input logic [63:0] exp_data, input logic exp_ill);
    exp_t e;
    resp_ready = rdy;
    @(negedge sys_clk);
    chk("req0_ready", 64'(req0_ready), 64'(exp_g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(exp_g == 1));
    if (exp_g != 2) begin
      e.port = (exp_g == 1);
      e.data = exp_data;
      e.zero = (exp_data == 64'd0);
      e.ill  = exp_ill;
      exp_q.push_back(e);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_drain();
    drive0(1'b0, 4'b0000, 64'd0, 64'd0);
    drive1(1'b0, 4'b0000, 64'd0, 64'd0);
    step(1'b1, 2, 64'd0, 1'b0);
    step(1'b1, 2, 64'd0, 1'b0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    resp_ready = 1'b0;
    drive0(1'b0, 4'b0000, 64'd0, 64'd0);
    drive1(1'b0, 4'b0000, 64'd0, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_cnt0",       64'(grant_cnt0), 64'd0);
    chk("rst_resp_data",  resp_data,       64'd0);

    // Single ADD from port 0
    drive0(1'b1, 4'b0010, 64'd5, 64'd7);
    step(1'b1, 0, 64'd12, 1'b0);
    chk("add_resp_valid", 64'(resp_valid), 64'd1);
    chk("add_resp_port",  64'(resp_port),  64'd0);
    chk("add_resp_data",  resp_data,       64'd12);
    chk("add_resp_zero",  64'(resp_zero),  64'd0);
    chk("add_cnt0",       64'(grant_cnt0), 64'd1);
    idle_drain();

    // Both valid continuously: alternating grants from port 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 4'b0010, 64'(i), 64'd10);
      drive1(1'b1, 4'b0010, 64'(i), 64'd100);
      step(1'b1, i % 2, (i % 2 == 0) ? 64'(i + 10) : 64'(i + 100), 1'b0);
    end
    idle_drain();
    chk("rr_cnt0", 64'(grant_cnt0), 64'd2);
    chk("rr_cnt1", 64'(grant_cnt1), 64'd2);

    // Backpressure: SUB 3-3 held while resp_ready is low
    drive1(1'b1, 4'b0110, 64'd3, 64'd3);
    step(1'b0, 1, 64'd0, 1'b0);
    drive0(1'b1, 4'b0010, 64'd1, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2, 64'd0, 1'b0);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_port",  64'(resp_port),  64'd1);
      chk("hold_data",  resp_data,       64'd0);
      chk("hold_zero",  64'(resp_zero),  64'd1);
    end
    drive1(1'b0, 4'b0000, 64'd0, 64'd0);
    drive0(1'b1, 4'b0010, 64'd4, 64'd4);
    step(1'b1, 0, 64'd8, 1'b0);
    idle_drain();

    // Opcode coverage and boundaries, port 0 alone
    drive0(1'b1, 4'b0110, 64'd0, 64'd1);                 step(1'b1, 0, ONES, 1'b0);
    drive0(1'b1, 4'b0111, 64'd1, 64'd2);                 step(1'b1, 0, 64'd1, 1'b0);
    drive0(1'b1, 4'b0111, 64'd2, 64'd1);                 step(1'b1, 0, 64'd0, 1'b0);
    drive0(1'b1, 4'b0111, ONES, 64'd1);                  step(1'b1, 0, 64'd0, 1'b0);
    drive0(1'b1, 4'b1111, 64'd9, 64'd9);                 step(1'b1, 0, 64'd0, 1'b1);
    drive0(1'b1, 4'b0000, 64'hF0F0, 64'hFF00);           step(1'b1, 0, 64'hF000, 1'b0);
    drive0(1'b1, 4'b0001, 64'hF0F0, 64'h0F0F);           step(1'b1, 0, 64'hFFFF, 1'b0);
    drive0(1'b1, 4'b1100, 64'd0, 64'd0);                 step(1'b1, 0, ONES, 1'b0);
    drive0(1'b1, 4'b1100, ONES, 64'd0);                  step(1'b1, 0, 64'd0, 1'b0);
    drive0(1'b1, 4'b0010, ONES, 64'd2);                  step(1'b1, 0, 64'd1, 1'b0);
    drive0(1'b1, 4'b0011, 64'd1, 64'd1);                 step(1'b1, 0, 64'd0, 1'b1);
    idle_drain();

    // Asynchronous reset in the middle of HOLD
    drive1(1'b1, 4'b0010, 64'd1, 64'd2);
    step(1'b0, 1, 64'd3, 1'b0);
    drive0(1'b1, 4'b0010, 64'd1, 64'd1);
    #3;
    sys_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_cnt0",       64'(grant_cnt0), 64'd0);
    chk("arst_cnt1",       64'(grant_cnt1), 64'd0);
    chk("arst_req0_ready", 64'(req0_ready), 64'd0);
    chk("arst_req1_ready", 64'(req1_ready), 64'd0);
    chk("arst_resp_data",  resp_data,       64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    drive0(1'b1, 4'b0010, 64'd20, 64'd1);
    drive1(1'b1, 4'b0010, 64'd30, 64'd1);
    step(1'b1, 0, 64'd21, 1'b0);
    step(1'b1, 1, 64'd31, 1'b0);
    idle_drain();

    // Saturation: 2^CNT_W+3 grants to port 0
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive0(1'b1, 4'b0010, 64'(i), 64'd1);
      step(1'b1, 0, 64'(i + 1), 1'b0);
    end
    idle_drain();
    chk("sat_cnt0", 64'(grant_cnt0), 64'd15);
    chk("sat_cnt1", 64'(grant_cnt1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/risc_v_alu_arb.md
RISC_V_ALU_ARB -- requirements
Module: risc_v_alu_arb

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width in bits.
REQ-002 Parameter CNT_W, default 16, width of per-port grant counters.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester n operation accepted this cycle when valid&ready.
REQ-007 req0_ctl / req1_ctl  input  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT unsigned, 1100 NOR.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-009 resp_valid  output  1  result register holds an undelivered result.
REQ-010 resp_ready  input  1  consumer takes result when resp_valid&resp_ready.
REQ-011 resp_port  output  1  index of the requester that owns the result.
REQ-012 resp_data  output  DATA_W  ALU result.
REQ-013 resp_zero  output  1  resp_data == 0.
REQ-014 resp_illegal  output  1  opcode was outside the legal set of REQ-007.
REQ-015 grant_cnt0 / grant_cnt1  output  CNT_W  saturating count of accepted operations per port.

Function
REQ-016 FSM has two states: IDLE (result register empty) and HOLD (result register full).
REQ-017 Accept condition per cycle: state IDLE, or state HOLD with resp_ready=1 (drain and refill in the same cycle).
REQ-018 When the accept condition holds, at most one of req0_ready/req1_ready SHALL be 1, and only toward a valid requester; both SHALL be 0 otherwise.
REQ-019 Only one requester valid: that requester is granted.
REQ-020 Both valid: the port selected by the round-robin pointer rr is granted; after any grant rr SHALL point to the other port.
REQ-021 Granted operation is computed combinationally by the ALU sub-module and captured into the result register on the grant edge; latency request-accept to resp_valid = 1 cycle.
REQ-022 Arithmetic is modulo 2^DATA_W; SLT is an unsigned compare producing 1 or 0 zero-extended.
REQ-023 Illegal opcode: resp_data=0, resp_zero=1, resp_illegal=1; the operation still counts as a grant.
REQ-024 IDLE -> HOLD on grant; HOLD -> IDLE on resp_ready with no grant; HOLD -> HOLD on resp_ready with grant (new result replaces old) or on resp_ready=0 (all resp_* outputs stable).
REQ-025 ready SHALL NOT depend on the requester's own ctl/a/b; it may depend on req*_valid, resp_ready, state and rr.
REQ-026 A grant counter increments by 1 per grant of its port and saturates at 2^CNT_W-1.

Reset
REQ-027 On sys_rst asserted (any time, including while in HOLD): state=IDLE, resp_valid=0, resp_port=0, resp_data=0, resp_zero=0, resp_illegal=0, rr=0 (port 0 favoured), grant_cnt0=grant_cnt1=0, req*_ready=0.
REQ-028 A result pending at reset is discarded; first grant after deassertion occurs no earlier than the first rising edge with sys_rst=0.

Structure
REQ-029 Opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR) and the FSM state encoding SHALL live in the shared package risc_v_pkg.
REQ-030 One sub-module SHALL be instantiated: risc_v_alu, driven by the muxed granted operands; its zero output is registered as resp_zero.

Verification
REQ-031 Reset, then req0 ADD a=5 b=7 alone, resp_ready=1 -> req0_ready=1 that cycle, next cycle resp_valid=1, resp_port=0, resp_data=12, resp_zero=0, grant_cnt0=1.
REQ-032 Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 with one result per cycle, starting with port 0.
REQ-033 req1 SUB a=3 b=3, resp_ready=0 for 4 cycles -> resp_valid=1, resp_data=0, resp_zero=1 held stable, req0_ready=req1_ready=0 throughout; resp_ready=1 then frees next grant.
REQ-034 req0 SUB a=0 b=1 -> resp_data=all ones (wrap); req0 SLT a=1 b=2 -> resp_data=1; opcode 1111 -> resp_data=0, resp_illegal=1.
REQ-035 sys_rst pulsed mid-HOLD, asynchronous to sys_clk -> resp_valid drops immediately, counters 0, rr back to port 0.
REQ-036 2^CNT_W+3 grants to port 0 (CNT_W overridden to 4) -> grant_cnt0 stays at 15.
